vga_char_render: RTL and testbench

Character-generation stage between the 80x30 tile screen buffer and the VGA output pins. From the sync generator's pixel counters it computes the buffer word address. It then extracts the 7-bit character code from the 28-bit packed word and fetches the glyph row from an external synchronous font ROM. It serialises the glyph bit into an RGB pixel, delaying de/hsync/vsync so all outputs stay aligned.

---
 rtl/vga_char_render.sv | 170 +++++++++++++++++
 tb/tb_vga_char_render.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_char_render.sv
// Text-mode character renderer: tile address -> buffer word -> font ROM -> pixel, 4-cycle fixed latency.
// Optional blinking cursor is enabled by defining VGA_CURSOR_EN.
module vga_char_render #(
  parameter int          H_TILES    = 80,
  parameter int          V_TILES    = 30,
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 28,
  parameter logic [11:0] FG_COLOR   = 12'hFFF,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [9:0]            hcount_i,
  input  logic [9:0]            vcount_i,
  input  logic                  de_i,
  input  logic                  hsync_i,
  input  logic                  vsync_i,
  output logic [ADDR_WIDTH-1:0] vr_addr_o,
  input  logic [DATA_WIDTH-1:0] buf_data_i,
  output logic [10:0]           font_addr_o,
  input  logic [7:0]            font_data_i,
  input  logic [6:0]            cursor_col_i,
  input  logic [4:0]            cursor_row_i,
  input  logic                  cursor_on_i,
  output logic [11:0]           rgb_o,
  output logic                  de_o,
  output logic                  hsync_o,
  output logic                  vsync_o
);

  logic [6:0]  col;
  logic [4:0]  row;
  logic [11:0] tile;

  assign col  = hcount_i[9:3];
  assign row  = vcount_i[8:4];
  assign tile = 12'(row) * 12'(H_TILES) + 12'(col);

  // Stage 1
  logic [ADDR_WIDTH-1:0] vr_addr_q, vr_addr_d;
  logic [1:0]            s1_slot_q;
  logic [3:0]            s1_grow_q;
  logic [2:0]            s1_px_q;
  logic                  s1_de_q, s1_hs_q, s1_vs_q;
  // Stage 2
  logic [1:0]            s2_slot_q;
  logic [3:0]            s2_grow_q;
  logic [2:0]            s2_px_q;
  logic                  s2_de_q, s2_hs_q, s2_vs_q;
  // Stage 3
  logic [2:0]            s3_px_q;
  logic                  s3_de_q, s3_hs_q, s3_vs_q;
  // Stage 4 (outputs)
  logic [11:0]           rgb_q, rgb_d;
  logic                  de_q, hs_q, vs_q;

  // Address holds through blanking so the buffer never sees a word >= 600.
  assign vr_addr_d = de_i ? ADDR_WIDTH'(tile[11:2]) : vr_addr_q;

  logic [6:0] char_sel;
  always_comb begin
    char_sel = buf_data_i[6:0];
    case (s2_slot_q)
      2'd0: char_sel = buf_data_i[6:0];
      2'd1: char_sel = buf_data_i[13:7];
      2'd2: char_sel = buf_data_i[20:14];
      2'd3: char_sel = buf_data_i[27:21];
      default: char_sel = buf_data_i[6:0];
    endcase
  end

  assign font_addr_o = {char_sel, s2_grow_q};

  logic glyph_bit;
  logic pix_bit;
  // ~px equals 7-px for a 3-bit column, so MSB is the leftmost pixel.
  assign glyph_bit = font_data_i[~s3_px_q];

`ifdef VGA_CURSOR_EN
  logic       s1_match_q, s2_match_q, s3_match_q, s1_match_d;
  logic [4:0] blink_cnt_q, blink_cnt_d;
  logic       vs_prev_q;

  assign s1_match_d  = cursor_on_i && (col == cursor_col_i) && (row == cursor_row_i);
  assign blink_cnt_d = (vs_prev_q && !vsync_i) ? blink_cnt_q + 5'd1 : blink_cnt_q;
  assign pix_bit     = glyph_bit ^ (s3_match_q & blink_cnt_q[4]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_match_q  <= 1'b0;
      s2_match_q  <= 1'b0;
      s3_match_q  <= 1'b0;
      blink_cnt_q <= 5'd0;
      vs_prev_q   <= 1'b1;
    end else begin
      s1_match_q  <= s1_match_d;
      s2_match_q  <= s1_match_q;
      s3_match_q  <= s2_match_q;
      blink_cnt_q <= blink_cnt_d;
      vs_prev_q   <= vsync_i;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{vcount_i[9], 1'b0};
`else
  assign pix_bit = glyph_bit;

  logic unused_ok;
  assign unused_ok = ^{vcount_i[9], cursor_col_i, cursor_row_i, cursor_on_i};
`endif

  assign rgb_d = s3_de_q ? (pix_bit ? FG_COLOR : BG_COLOR) : 12'h000;

  // Sync delay stages reset high so no false sync pulse leaves the pipe after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vr_addr_q <= '0;
      s1_slot_q <= 2'd0;
      s1_grow_q <= 4'd0;
      s1_px_q   <= 3'd0;
      s1_de_q   <= 1'b0;
      s1_hs_q   <= 1'b1;
      s1_vs_q   <= 1'b1;
      s2_slot_q <= 2'd0;
      s2_grow_q <= 4'd0;
      s2_px_q   <= 3'd0;
      s2_de_q   <= 1'b0;
      s2_hs_q   <= 1'b1;
      s2_vs_q   <= 1'b1;
      s3_px_q   <= 3'd0;
      s3_de_q   <= 1'b0;
      s3_hs_q   <= 1'b1;
      s3_vs_q   <= 1'b1;
      rgb_q     <= 12'h000;
      de_q      <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
    end else begin
      vr_addr_q <= vr_addr_d;
      s1_slot_q <= tile[1:0];
      s1_grow_q <= vcount_i[3:0];
      s1_px_q   <= hcount_i[2:0];
      s1_de_q   <= de_i;
      s1_hs_q   <= hsync_i;
      s1_vs_q   <= vsync_i;
      s2_slot_q <= s1_slot_q;
      s2_grow_q <= s1_grow_q;
      s2_px_q   <= s1_px_q;
      s2_de_q   <= s1_de_q;
      s2_hs_q   <= s1_hs_q;
      s2_vs_q   <= s1_vs_q;
      s3_px_q   <= s2_px_q;
      s3_de_q   <= s2_de_q;
      s3_hs_q   <= s2_hs_q;
      s3_vs_q   <= s2_vs_q;
      rgb_q     <= rgb_d;
      de_q      <= s3_de_q;
      hs_q      <= s3_hs_q;
      vs_q      <= s3_vs_q;
    end
  end

  assign vr_addr_o = vr_addr_q;
  assign rgb_o     = rgb_q;
  assign de_o      = de_q;
  assign hsync_o   = hs_q;
  assign vsync_o   = vs_q;

endmodule

// File: tb/tb_vga_char_render.sv
// Bench for vga_char_render: models the screen buffer and font ROM, scoreboards {rgb,de,hsync,vsync}.
// Cursor expectations follow VGA_CURSOR_EN when the bench is built with it.
module tb_vga_char_render;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [9:0]  hcount_i, vcount_i;
  logic        de_i, hsync_i, vsync_i;
  logic [9:0]  vr_addr_o;
  logic [27:0] buf_data_i;
  logic [10:0] font_addr_o;
  logic [7:0]  font_data_i;
  logic [6:0]  cursor_col_i;
  logic [4:0]  cursor_row_i;
  logic        cursor_on_i;
  logic [11:0] rgb_o;
  logic        de_o, hsync_o, vsync_o;

  vga_char_render dut (
    .clk_i(clk_i), .rst_i(rst_i), .hcount_i(hcount_i), .vcount_i(vcount_i),
    .de_i(de_i), .hsync_i(hsync_i), .vsync_i(vsync_i), .vr_addr_o(vr_addr_o),
    .buf_data_i(buf_data_i), .font_addr_o(font_addr_o), .font_data_i(font_data_i),
    .cursor_col_i(cursor_col_i), .cursor_row_i(cursor_row_i), .cursor_on_i(cursor_on_i),
    .rgb_o(rgb_o), .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
  );

  always #20 clk_i = ~clk_i;

  // External synchronous memories
  logic [27:0] vmem [0:1023];
  logic [7:0]  fmem [0:2047];
  always @(posedge clk_i) begin
    buf_data_i  <= vmem[vr_addr_o];
    font_data_i <= fmem[font_addr_o];
  end

  localparam logic [14:0] RESET_EXP = {12'h000, 1'b0, 1'b1, 1'b1};
`ifdef VGA_CURSOR_EN
  localparam logic [11:0] CUR_BLINK_RGB = 12'hFFF;
`else
  localparam logic [11:0] CUR_BLINK_RGB = 12'h000;
`endif

  logic [14:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [4:0]  m_cnt = 5'd0;
  logic        m_prev = 1'b1;

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        de;
    logic [11:0] rgb;
  } vec_t;
  vec_t tbl [10];

  function automatic logic [14:0] model(input logic [9:0] h, input logic [9:0] v,
                                        input logic de, input logic hs, input logic vs);
    int          tile;
    int          slot;
    logic [27:0] w;
    logic [6:0]  ch;
    logic [7:0]  g;
    logic        b;
    tile = int'(v[8:4]) * 80 + int'(h[9:3]);
    slot = tile % 4;
    w    = vmem[tile / 4];
    ch   = w[slot*7 +: 7];
    g    = fmem[{ch, v[3:0]}];
    b    = g[7 - int'(h[2:0])];
`ifdef VGA_CURSOR_EN
    if (cursor_on_i && m_cnt[4] && h[9:3] == cursor_col_i && v[8:4] == cursor_row_i) b = ~b;
`endif
    return {de ? (b ? 12'hFFF : 12'h000) : 12'h000, de, hs, vs};
  endfunction

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [9:0] h, input logic [9:0] v,
                      input logic de, input logic hs, input logic vs,
                      input logic use_exp, input logic [14:0] exp_v);
    logic [14:0] e;
    @(negedge clk_i);
    if (exp_q.size() == 4) begin
      e = exp_q.pop_front();
      checks++;
      if ({rgb_o, de_o, hsync_o, vsync_o} !== e) begin
        failures++;
        $display("FAIL pipe h=%0d v=%0d got=%h exp=%h", hcount_i, vcount_i,
                 {rgb_o, de_o, hsync_o, vsync_o}, e);
      end
    end
    rst_i = r; hcount_i = h; vcount_i = v; de_i = de; hsync_i = hs; vsync_i = vs;
    if (r) begin
      exp_q.delete();
      repeat (4) exp_q.push_back(RESET_EXP);
      m_cnt  = 5'd0;
      m_prev = 1'b1;
    end else begin
      if (m_prev && !vs) m_cnt = m_cnt + 5'd1;
      m_prev = vs;
      exp_q.push_back(use_exp ? exp_v : model(h, v, de, hs, vs));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 10'd700, 10'd490, 1'b0, 1'b1, 1'b1, 1'b0, '0);
  endtask

  task automatic vs_falls(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 10'd700, 10'd490, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      step(1'b0, 10'd700, 10'd491, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    end
  endtask

  task automatic cursor_span(input logic [11:0] rgb);
    for (int x = 40; x < 48; x++)
      step(1'b0, 10'(x), 10'd35, 1'b1, 1'b1, 1'b1, 1'b1, {rgb, 1'b1, 1'b1, 1'b1});
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) vmem[i] = 28'($urandom);
    for (int i = 0; i < 2048; i++) fmem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) fmem[i] = 8'h00;
    vmem[0]        = {7'h14, 7'h26, 7'h05, 7'h41};
    fmem[{7'h41, 4'd0}] = 8'b1000_0001;
    vmem[41][13:7] = 7'h00;
    cursor_col_i = 7'd5; cursor_row_i = 5'd2; cursor_on_i = 1'b0;
    rst_i = 1'b1; hcount_i = 10'd700; vcount_i = 10'd490;
    de_i = 1'b0; hsync_i = 1'b1; vsync_i = 1'b1;

    tbl[0] = '{10'd0, 10'd0, 1'b1, 12'hFFF};
    tbl[1] = '{10'd1, 10'd0, 1'b1, 12'h000};
    tbl[2] = '{10'd2, 10'd0, 1'b1, 12'h000};
    tbl[3] = '{10'd3, 10'd0, 1'b1, 12'h000};
    tbl[4] = '{10'd4, 10'd0, 1'b1, 12'h000};
    tbl[5] = '{10'd5, 10'd0, 1'b1, 12'h000};
    tbl[6] = '{10'd6, 10'd0, 1'b1, 12'h000};
    tbl[7] = '{10'd7, 10'd0, 1'b1, 12'hFFF};
    tbl[8] = '{10'd0, 10'd0, 1'b0, 12'h000};
    tbl[9] = '{10'd7, 10'd0, 1'b0, 12'h000};

    step(1'b1, 10'd700, 10'd490, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 10'd700, 10'd490, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    chk("rst_vr_addr", 12'(vr_addr_o), 12'd0);

    // Pixel serialisation table
    for (int i = 0; i < 10; i++)
      step(1'b0, tbl[i].h, tbl[i].v, tbl[i].de, 1'b1, 1'b1, 1'b1,
           {tbl[i].rgb, tbl[i].de, 1'b1, 1'b1});

    // Address math and hold during blanking
    step(1'b0, 10'd639, 10'd479, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 10'd700, 10'd479, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    chk("vr_addr_last", 12'(vr_addr_o), 12'd599);
    step(1'b0, 10'd700, 10'd479, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    chk("vr_addr_hold", 12'(vr_addr_o), 12'd599);

    // Slot extraction
    step(1'b0, 10'd24, 10'd5, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 10'd25, 10'd5, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 10'd26, 10'd5, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    chk("font_addr_slot3", 12'(font_addr_o), 12'({7'h14, 4'd5}));
    step(1'b0, 10'd0, 10'd5, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 10'd1, 10'd5, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 10'd2, 10'd5, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    chk("font_addr_slot0", 12'(font_addr_o), 12'({7'h41, 4'd5}));

    // Horizontal blanking with hsync pulse
    for (int h = 640; h < 800; h++)
      step(1'b0, 10'(h), 10'd479, 1'b0, (h >= 656 && h <= 751) ? 1'b0 : 1'b1, 1'b1, 1'b0, '0);

    // Random visible/blank traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0)
        step(1'b0, 10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)), 1'b1,
             1'($urandom_range(0, 1)), 1'b1, 1'b0, '0);
      else
        step(1'b0, 10'($urandom_range(640, 799)), 10'($urandom_range(0, 524)), 1'b0,
             1'($urandom_range(0, 1)), 1'b1, 1'b0, '0);
    end

    // Reset mid-line: the bright pixel at h=0 is in flight when reset hits
    for (int h = 0; h < 3; h++) step(1'b0, 10'(h), 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 10'd3, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int h = 0; h < 12; h++) step(1'b0, 10'(h % 8), 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, '0);

    // Cursor blink on tile 165 with a blank glyph
    step(1'b1, 10'd700, 10'd490, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    cursor_on_i = 1'b1;
    idle(2);
    cursor_span(12'h000);
    vs_falls(16);
    idle(6);
    cursor_span(CUR_BLINK_RGB);
    idle(6);
    vs_falls(16);
    idle(6);
    cursor_span(12'h000);
    cursor_on_i = 1'b0;
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
